// File: rtl/slb_mem_responder.sv
// Byte-wide memory responder for the load/store buffer: one byte per handshake,
// RAM read/write sequencing with an IO-region read delay. Optional macro IO_STALL_EN.
module slb_mem_responder #(
  parameter int         RAM_AW = 17,    // must not exceed 18 (latched address width)
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk_in,
  input  logic              rstn_in,
  input  logic              rdy_in,
  input  logic              access_control,
  input  logic              mem_wr,
  input  logic [31:0]       mem_addr,
  input  logic [7:0]        mem_dout,
  output logic              access_valid,
  output logic [7:0]        mem_din,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_we,
  output logic [7:0]        ram_d,
  input  logic [7:0]        ram_q,
  input  logic              io_buffer_full,
  output logic [31:0]       byte_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_e;

  state_e      state_q, state_d;
  logic [17:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  din_q, din_d;
  logic [31:0] count_q, count_d;
  logic        io_wait_q, io_wait_d;
  logic        accept;
  logic        unused_inputs;

`ifdef IO_STALL_EN
  assign unused_inputs = ^mem_addr[31:18];
`else
  assign unused_inputs = ^{mem_addr[31:18], io_buffer_full};
`endif

  // NOTE: every variable driven here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    data_d       = data_q;
    din_d        = din_q;
    count_d      = count_q;
    io_wait_d    = io_wait_q;
    access_valid = 1'b0;
    ram_we       = 1'b0;
    accept       = access_control;
`ifdef IO_STALL_EN
    // An IO write cannot start while the IO sink is full; nothing is latched.
    if (mem_wr && (mem_addr[17:16] == IO_HI) && io_buffer_full) accept = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = mem_addr[17:0];
          wr_d    = mem_wr;
          data_d  = mem_dout;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          ram_we  = rdy_in;
          state_d = DONE;
        end else begin
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        // IO reads sit here one extra cycle before sampling ram_q.
        if ((addr_q[17:16] == IO_HI) && !io_wait_q) begin
          io_wait_d = 1'b1;
        end else begin
          io_wait_d = 1'b0;
          din_d     = ram_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        access_valid = rdy_in;
        state_d      = IDLE;
        if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      din_q     <= '0;
      count_q   <= '0;
      io_wait_q <= 1'b0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      din_q     <= din_d;
      count_q   <= count_d;
      io_wait_q <= io_wait_d;
    end
  end

  assign ram_a      = addr_q[RAM_AW-1:0];
  assign ram_d      = data_q;
  assign mem_din    = din_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_slb_mem_responder.sv
// Self-checking bench for slb_mem_responder: directed scenarios followed by
// randomized requests checked against a latency/memory reference model.
module tb_slb_mem_responder;

  logic        clk_in = 1'b0;
  logic        rstn_in, rdy_in, access_control, mem_wr, io_buffer_full;
  logic [31:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        access_valid, ram_we;
  logic [7:0]  mem_din, ram_d, ram_q;
  logic [16:0] ram_a;
  logic [31:0] byte_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [int];
  logic [31:0] exp_count;
  logic [7:0]  exp_din;

  logic [7:0]  tb_ram [0:(1<<17)-1];
  logic        pre_we;
  logic [16:0] pre_a;
  logic [7:0]  pre_d;

  slb_mem_responder dut (
    .clk_in(clk_in), .rstn_in(rstn_in), .rdy_in(rdy_in),
    .access_control(access_control), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .access_valid(access_valid), .mem_din(mem_din),
    .ram_a(ram_a), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q),
    .io_buffer_full(io_buffer_full), .byte_count(byte_count)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous-read RAM with a bench-side preload port.
  always @(posedge clk_in) begin
    if (pre_we)      tb_ram[pre_a] <= pre_d;
    else if (ram_we) tb_ram[ram_a] <= ram_d;
    ram_q <= tb_ram[ram_a];
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic wr, input logic [31:0] a);
    if (wr) return 2;
    return (a[17:16] == 2'b11) ? 4 : 3;
  endfunction

  task automatic preload(input logic [16:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    ref_mem[int'(a)] = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (access_valid) break;
    end
  endtask

  // One request from IDLE: checks latency, RAM strobe, returned byte and counter.
  task automatic serve(input logic wr, input logic [31:0] addr, input logic [7:0] data, input string tag);
    int n, we_at, we_cnt;
    logic [16:0] we_a;
    logic [7:0]  we_d;
    access_control = 1'b1; mem_wr = wr; mem_addr = addr; mem_dout = data;
    n = 0; we_at = 0; we_cnt = 0; we_a = '0; we_d = '0;
    while (n < 20) begin
      step();
      n++;
      if (ram_we) begin
        we_cnt++;
        if (we_at == 0) begin we_at = n; we_a = ram_a; we_d = ram_d; end
      end
      if (access_valid) break;
    end
    access_control = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(exp_lat(wr, addr)));
    check({tag, "_we_count"}, 32'(we_cnt), 32'(wr));
    if (wr) begin
      check({tag, "_we_cycle"}, 32'(we_at), 32'd1);
      check({tag, "_ram_a"}, 32'(we_a), 32'(addr[16:0]));
      check({tag, "_ram_d"}, 32'(we_d), 32'(data));
      ref_mem[int'(addr[16:0])] = data;
    end else begin
      exp_din = ref_mem[int'(addr[16:0])];
    end
    check({tag, "_mem_din"}, 32'(mem_din), 32'(exp_din));
    if (exp_count != 32'hFFFF_FFFF) exp_count++;
    step();
    check({tag, "_pulse_end"}, 32'(access_valid), 32'd0);
    check({tag, "_byte_count"}, byte_count, exp_count);
  endtask

  initial begin
    int n, pulses, wes, we_at;
    logic [31:0] a;

    rstn_in = 1'b0; rdy_in = 1'b1; access_control = 1'b0; mem_wr = 1'b0;
    mem_addr = '0; mem_dout = '0; io_buffer_full = 1'b0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    exp_count = '0; exp_din = '0;

    // Preload a pool of addresses in both halves of the RAM while in reset.
    for (int b = 0; b < 2; b++)
      for (int off = 0; off < 32; off++)
        preload({1'(b), 11'h0, 5'(off)}, 8'($urandom));
    preload(17'h00020, 8'h3C);
    preload(17'h10004, 8'h5A);

    check("rst_access_valid", 32'(access_valid), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_a", 32'(ram_a), 32'd0);
    check("rst_ram_d", 32'(ram_d), 32'd0);
    check("rst_byte_count", byte_count, 32'd0);

    // First request presented in the same cycle reset is released.
    rstn_in = 1'b1;
    serve(1'b1, 32'h0000_0010, 8'hA5, "wr_a5");

    // Held read: first pulse after 3 cycles, re-served 4 cycles later.
    access_control = 1'b1; mem_wr = 1'b0; mem_addr = 32'h0000_0020;
    wait_valid(n);
    check("held_rd_lat", 32'(n), 32'd3);
    check("held_rd_din", 32'(mem_din), 32'h3C);
    wait_valid(n);
    check("held_rd_spacing", 32'(n), 32'd4);
    access_control = 1'b0;
    exp_count += 2; exp_din = 8'h3C;
    step();
    check("held_rd_count", byte_count, exp_count);

    // Asynchronous reset in WAIT_RD abandons the read.
    access_control = 1'b1; mem_wr = 1'b0; mem_addr = 32'h0000_0020;
    step(); step();
    rstn_in = 1'b0;
    #1;
    check("midrst_access_valid", 32'(access_valid), 32'd0);
    check("midrst_mem_din", 32'(mem_din), 32'd0);
    check("midrst_ram_we", 32'(ram_we), 32'd0);
    check("midrst_ram_a", 32'(ram_a), 32'd0);
    check("midrst_ram_d", 32'(ram_d), 32'd0);
    check("midrst_byte_count", byte_count, 32'd0);
    access_control = 1'b0;
    step();
    rstn_in = 1'b1;
    pulses = 0; wes = 0;
    repeat (8) begin
      step();
      pulses += int'(access_valid);
      wes    += int'(ram_we);
    end
    check("midrst_no_pulse", 32'(pulses), 32'd0);
    check("midrst_no_write", 32'(wes), 32'd0);
    exp_count = '0; exp_din = '0;

    // IO read held for four back-to-back bytes.
    access_control = 1'b1; mem_wr = 1'b0; mem_addr = 32'h0003_0004;
    wait_valid(n);
    check("io_rd_lat", 32'(n), 32'd4);
    check("io_rd_din", 32'(mem_din), 32'h5A);
    for (int i = 0; i < 3; i++) begin
      wait_valid(n);
      check("io_rd_spacing", 32'(n), 32'd5);
    end
    access_control = 1'b0;
    exp_count = 32'd4; exp_din = 8'h5A;
    step();
    check("io_rd_count", byte_count, 32'd4);

    // IO write while the IO sink reports full for 5 cycles.
    io_buffer_full = 1'b1;
    access_control = 1'b1; mem_wr = 1'b1; mem_addr = 32'h0003_0000; mem_dout = 8'h77;
    n = 0; we_at = 0;
    while (n < 20) begin
      step();
      n++;
      if (ram_we && we_at == 0) we_at = n;
      if (n == 5) io_buffer_full = 1'b0;
      if (access_valid) break;
    end
    access_control = 1'b0; io_buffer_full = 1'b0;
`ifdef IO_STALL_EN
    check("io_wr_we_cycle", 32'(we_at), 32'd6);
    check("io_wr_lat", 32'(n), 32'd7);
`else
    check("io_wr_we_cycle", 32'(we_at), 32'd1);
    check("io_wr_lat", 32'(n), 32'd2);
`endif
    ref_mem[int'(17'h10000)] = 8'h77;
    exp_count++;
    step();
    check("io_wr_count", byte_count, exp_count);

    // rdy_in low for 3 cycles in DONE with the counter one below saturation.
    force dut.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    #1;
    check("preset_count", byte_count, 32'hFFFF_FFFE);
    access_control = 1'b1; mem_wr = 1'b1; mem_addr = 32'h0000_0011; mem_dout = 8'hC3;
    step();
    check("rdy_we_cycle1", 32'(ram_we), 32'd1);
    step();
    rdy_in = 1'b0; access_control = 1'b0;
    #1;
    pulses = int'(access_valid);
    repeat (3) begin
      step();
      pulses += int'(access_valid) + int'(ram_we);
    end
    check("rdy_frozen_quiet", 32'(pulses), 32'd0);
    check("rdy_frozen_count", byte_count, 32'hFFFF_FFFE);
    rdy_in = 1'b1;
    #1;
    check("rdy_deferred_pulse", 32'(access_valid), 32'd1);
    step();
    check("rdy_single_pulse", 32'(access_valid), 32'd0);
    check("rdy_count_sat", byte_count, 32'hFFFF_FFFF);
    ref_mem[int'(17'h00011)] = 8'hC3;
    exp_count = 32'hFFFF_FFFF;
    serve(1'b1, 32'h0000_0012, 8'h4B, "sat_wr");
    serve(1'b0, 32'h0000_0011, 8'h00, "sat_rd");

    // Randomized traffic over the preloaded pool.
    for (int i = 0; i < 40; i++) begin
      a = {14'($urandom), 2'($urandom), 11'h0, 5'($urandom)};
      repeat ($urandom_range(0, 2)) step();
      serve(1'($urandom), a, 8'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
